// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types and constants for the branch resolution slice.
//               Holds the default address/class widths, the opcode-class
//               constants, the in-flight queue entry layout and the
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

   localparam int DEF_ADDR_W  = 5;
   localparam int DEF_CLASS_W = 3;

   // Opcode classes used to index the predictor table.
   localparam logic [DEF_CLASS_W-1:0] c_CLS_LW    = 3'd0;
   localparam logic [DEF_CLASS_W-1:0] c_CLS_ITYPE = 3'd1;
   localparam logic [DEF_CLASS_W-1:0] c_CLS_SW    = 3'd2;
   localparam logic [DEF_CLASS_W-1:0] c_CLS_RTYPE = 3'd3;
   localparam logic [DEF_CLASS_W-1:0] c_CLS_UTYPE = 3'd4;
   localparam logic [DEF_CLASS_W-1:0] c_CLS_JAL   = 3'd5;
   localparam logic [DEF_CLASS_W-1:0] c_CLS_OTHER = 3'd6;

   // One in-flight branch. The FIFO stores entries as a flat vector with
   // exactly this field order, MSB first.
   typedef struct packed {
      logic                   taken;
      logic [DEF_CLASS_W-1:0] cls;
      logic [DEF_ADDR_W-1:0]  target;
      logic [DEF_ADDR_W-1:0]  fallthru;
   } branch_entry_t;

   typedef enum logic [0:0] {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_inflight_fifo.sv
`default_nettype none
// ============================================================================
// Module      : branch_inflight_fifo
// Description : DEPTH-entry synchronous FIFO holding in-flight branches in
//               program order. Clear has priority over push and pop.
// Ports       : clk, rst_n        - clock, async active-low reset
//               push, push_data   - enqueue (ignored when full)
//               pop               - dequeue head (ignored when empty)
//               clear             - drop every entry
//               head_data         - oldest entry (valid when !empty)
//               count, full, empty- occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module branch_inflight_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 14
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   clear,
   output logic [WIDTH-1:0]       head_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int c_PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign full      = (r_count == (c_PTR_W+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign head_data = r_mem[r_rd_ptr];

   assign w_do_push = push && !full && !clear;
   assign w_do_pop  = pop && !empty && !clear;

   // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH for free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_ctrl
// Description : Tracks fetch-time branch predictions in order, compares the
//               oldest one with the execute outcome, and on a mispredict
//               flushes the pipeline, redirects the PC and drops all younger
//               entries. Every resolution produces a one-cycle training pulse.
// Ports       : pred_*     - prediction from fetch, pred_ready handshake
//               res_*      - resolution of the oldest branch from execute
//               flush      - kill younger stages (FLUSH_CYCLES cycles)
//               redirect_* - one-cycle corrected-PC strobe, PC held after
//               upd_*      - one-cycle predictor training strobe
//               inflight   - queue occupancy
//               err_orphan - sticky: resolution seen with an empty queue
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl
   import branch_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DEPTH        = 4,
   parameter int CLASS_W      = DEF_CLASS_W,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pred_valid,
   input  logic                   pred_taken,
   input  logic [CLASS_W-1:0]     pred_class,
   input  logic [ADDR_W-1:0]      pred_target,
   input  logic [ADDR_W-1:0]      pred_fallthru,
   output logic                   pred_ready,
   input  logic                   res_valid,
   input  logic                   res_taken,
   output logic                   flush,
   output logic                   redirect_valid,
   output logic [ADDR_W-1:0]      redirect_pc,
   output logic                   upd_valid,
   output logic [CLASS_W-1:0]     upd_class,
   output logic                   upd_taken,
   output logic                   upd_mispredict,
   output logic [$clog2(DEPTH):0] inflight,
   output logic                   err_orphan
);

   localparam int c_ENTRY_W = 1 + CLASS_W + 2*ADDR_W;
   localparam int c_CNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_FLUSH_LOAD = c_CNT_W'(FLUSH_CYCLES-1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_flush_cnt;
   logic [c_CNT_W-1:0]   w_flush_cnt_nxt;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_orphan;
   logic                 w_mispredict;
   logic [c_ENTRY_W-1:0] w_push_data;
   logic [c_ENTRY_W-1:0] w_head_data;

   logic                 w_head_taken;
   logic [CLASS_W-1:0]   w_head_class;
   logic [ADDR_W-1:0]    w_head_target;
   logic [ADDR_W-1:0]    w_head_fallthru;

   assign w_push_data = {pred_taken, pred_class, pred_target, pred_fallthru};
   assign {w_head_taken, w_head_class, w_head_target, w_head_fallthru} = w_head_data;

   branch_inflight_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (c_ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .clear     (w_mispredict),
      .head_data (w_head_data),
      .count     (inflight),
      .full      (w_full),
      .empty     (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_RUN;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      w_pop           = 1'b0;
      w_orphan        = 1'b0;
      w_mispredict    = 1'b0;
      w_push          = 1'b0;
      // No look-ahead for a same-cycle pop: a full queue stays not-ready.
      pred_ready      = (r_state == S_RUN) && !w_full;
      flush           = (r_state == S_FLUSH);
      case (r_state)
         S_RUN: begin
            w_pop        = res_valid && !w_empty;
            w_orphan     = res_valid && w_empty;
            w_mispredict = w_pop && (w_head_taken != res_taken);
            // A push alongside a mispredict is wrong-path and is dropped.
            w_push       = pred_valid && pred_ready && !w_mispredict;
            if (w_mispredict) begin
               w_state_nxt     = S_FLUSH;
               w_flush_cnt_nxt = c_FLUSH_LOAD;
            end
         end
         S_FLUSH: begin
            if (r_flush_cnt == '0) begin
               w_state_nxt = S_RUN;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt - c_CNT_W'(1);
            end
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // Training and redirect outputs, one cycle after the resolving edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_valid      <= 1'b0;
         upd_class      <= '0;
         upd_taken      <= 1'b0;
         upd_mispredict <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         err_orphan     <= 1'b0;
      end else begin
         upd_valid      <= w_pop;
         redirect_valid <= w_mispredict;
         if (w_pop) begin
            upd_class      <= w_head_class;
            upd_taken      <= res_taken;
            upd_mispredict <= w_mispredict;
         end
         if (w_mispredict) begin
            redirect_pc <= res_taken ? w_head_target : w_head_fallthru;
         end
         if (w_orphan) begin
            err_orphan <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
